// File: rtl/estagio_busca_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pkg_busca;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        RETIDO   = 2'd1,
        DESCARTE = 2'd2
    } estado_t;

    localparam logic [31:0] NOP                = 32'h00000000;
    localparam logic [31:0] VETOR_RESET_PADRAO = 32'h00000000;

endpackage

// File: rtl/estagio_busca_registrador_if_id.sv
// IF/ID pipeline register: load wins over hold, flush wins over load and only
// clears the valid bit so the held instruction/link data stay observable.
module registrador_if_id
    import pkg_busca::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic               descarta,
    input  logic [LARGURA-1:0] instrucao,
    input  logic [LARGURA-1:0] pc_mais4,
    output logic [LARGURA-1:0] instrucao_id,
    output logic [LARGURA-1:0] pc_mais4_id,
    output logic               valido_id
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instrucao_id <= LARGURA'(NOP);
            pc_mais4_id  <= '0;
            valido_id    <= 1'b0;
        end else if (descarta) begin
            valido_id <= 1'b0;
        end else if (carrega) begin
            instrucao_id <= instrucao;
            pc_mais4_id  <= pc_mais4;
            valido_id    <= 1'b1;
        end
    end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, runs the req/ready handshake with
// instruction memory and feeds the IF/ID register consumed by decode.
module estagio_busca
    import pkg_busca::*;
#(
    parameter int                 LARGURA     = 32,
    parameter logic [LARGURA-1:0] VETOR_RESET = LARGURA'(VETOR_RESET_PADRAO)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hazard,
    input  logic               redireciona,
    input  logic [LARGURA-1:0] alvo,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_endereco,
    input  logic               mem_pronto,
    input  logic [LARGURA-1:0] mem_dado,
    output logic [LARGURA-1:0] instrucao_id,
    output logic [LARGURA-1:0] pc_mais4_id,
    output logic               valido_id,
    output logic               erro_alinhamento
);

    estado_t            estado, prox_estado;
    logic [LARGURA-1:0] pc, prox_pc;
    logic [LARGURA-1:0] pc_pendente, prox_pendente;
    logic [LARGURA-1:0] buffer, prox_buffer;
    logic [LARGURA-1:0] pc_mais4, alvo_alinhado, dado_if;
    logic               carrega, descarta;

    assign pc_mais4      = pc + LARGURA'(4);
    assign alvo_alinhado = {alvo[LARGURA-1:2], 2'b00};
    assign mem_req       = !reset && (estado != RETIDO);
    assign mem_endereco  = {pc[LARGURA-1:2], 2'b00};

    // Redirect outranks hazard: a taken branch always flushes the slot.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        prox_estado   = estado;
        prox_pc       = pc;
        prox_pendente = pc_pendente;
        prox_buffer   = buffer;
        dado_if       = mem_dado;
        carrega       = 1'b0;
        descarta      = 1'b0;

        if (redireciona) begin
            descarta = 1'b1;
            case (estado)
                REQ: begin
                    if (mem_pronto) begin
                        prox_pc = alvo_alinhado;
                    end else begin
                        prox_pendente = alvo_alinhado;
                        prox_estado   = DESCARTE;
                    end
                end
                DESCARTE: begin
                    prox_pendente = alvo_alinhado;
                    if (mem_pronto) begin
                        prox_pc     = alvo_alinhado;
                        prox_estado = REQ;
                    end
                end
                RETIDO: begin
                    prox_buffer = '0;
                    prox_pc     = alvo_alinhado;
                    prox_estado = REQ;
                end
                default: prox_estado = REQ;
            endcase
        end else begin
            case (estado)
                REQ: begin
                    if (mem_pronto) begin
                        if (hazard) begin
                            prox_buffer = mem_dado;
                            prox_estado = RETIDO;
                        end else begin
                            carrega = 1'b1;
                            prox_pc = pc_mais4;
                        end
                    end else if (!hazard) begin
                        descarta = 1'b1;
                    end
                end
                RETIDO: begin
                    if (!hazard) begin
                        carrega     = 1'b1;
                        dado_if     = buffer;
                        prox_pc     = pc_mais4;
                        prox_estado = REQ;
                    end
                end
                DESCARTE: begin
                    // The stale response is swallowed; the real fetch starts at the pending target.
                    if (mem_pronto) begin
                        prox_pc     = pc_pendente;
                        prox_estado = REQ;
                    end
                    if (!hazard) descarta = 1'b1;
                end
                default: prox_estado = REQ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= REQ;
            pc               <= VETOR_RESET;
            pc_pendente      <= '0;
            buffer           <= '0;
            erro_alinhamento <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
            estado           <= prox_estado;
            pc               <= prox_pc;
            pc_pendente      <= prox_pendente;
            buffer           <= prox_buffer;
            erro_alinhamento <= redireciona && (alvo[1:0] != 2'b00);
        end
    end

    registrador_if_id #(
        .LARGURA(LARGURA)
    ) u_if_id (
        .clock       (clock),
        .reset       (reset),
        .carrega     (carrega),
        .descarta    (descarta),
        .instrucao   (dado_if),
        .pc_mais4    (pc_mais4),
        .instrucao_id(instrucao_id),
        .pc_mais4_id (pc_mais4_id),
        .valido_id   (valido_id)
    );

endmodule

// File: tb/tb_estagio_busca.sv
// Self-checking bench for estagio_busca: behavioural fetch model, variable-latency
// memory responder, directed scenarios and a randomized run.
module tb_estagio_busca;

    localparam logic [31:0] VR = 32'h00400000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hazard = 1'b0;
    logic        redireciona = 1'b0;
    logic [31:0] alvo = 32'h0;
    logic        mem_pronto = 1'b0;
    logic [31:0] mem_dado = 32'h0;
    logic        mem_req;
    logic [31:0] mem_endereco;
    logic [31:0] instrucao_id;
    logic [31:0] pc_mais4_id;
    logic        valido_id;
    logic        erro_alinhamento;

    estagio_busca #(
        .LARGURA    (32),
        .VETOR_RESET(VR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .hazard          (hazard),
        .redireciona     (redireciona),
        .alvo            (alvo),
        .mem_req         (mem_req),
        .mem_endereco    (mem_endereco),
        .mem_pronto      (mem_pronto),
        .mem_dado        (mem_dado),
        .instrucao_id    (instrucao_id),
        .pc_mais4_id     (pc_mais4_id),
        .valido_id       (valido_id),
        .erro_alinhamento(erro_alinhamento)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        n_tests++;
        if (obtido !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nome, obtido, esperado, $time);
        end
    endtask

    // Instruction memory image.
    function automatic logic [31:0] img(input logic [31:0] a);
        if (a == 32'h00000008) return 32'h8C220004;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory responder: per-request latency drawn from [lat_min, lat_max].
    int lat_min = 0, lat_max = 0, lat_cur = 0, cnt = 0;
    always @(negedge clock) begin
        #2;
        if (reset || !mem_req) begin
            mem_pronto = 1'b0;
            cnt = 0;
        end else begin
            if (cnt == 0) lat_cur = $urandom_range(lat_max, lat_min);
            if (cnt >= lat_cur) begin
                mem_pronto = 1'b1;
                mem_dado   = img(mem_endereco);
                cnt = 0;
            end else begin
                mem_pronto = 1'b0;
                mem_dado   = $urandom;
                cnt++;
            end
        end
    end

    // Behavioural model: where the PC is, whether a fetched word is parked
    // because of a stall, and whether a request in flight belongs to a dead path.
    logic [31:0] m_pc, m_pend, m_buf, m_instr, m_pc4;
    bit          m_buffered, m_stale, m_valid, m_err;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc = VR; m_pend = 0; m_buf = 0; m_instr = 0; m_pc4 = 0;
            m_buffered = 0; m_stale = 0; m_valid = 0; m_err = 0;
        end else begin
            m_err = redireciona && (alvo[1:0] != 2'b00);
            if (redireciona) begin
                m_valid = 0;
                if (m_buffered) begin
                    m_buffered = 0;
                    m_pc = alvo & ~32'h3;
                end else if (mem_pronto) begin
                    m_stale = 0;
                    m_pc = alvo & ~32'h3;
                end else begin
                    m_stale = 1;
                    m_pend = alvo & ~32'h3;
                end
            end else if (m_buffered) begin
                if (!hazard) begin
                    m_instr = m_buf; m_pc4 = m_pc + 4; m_valid = 1;
                    m_pc = m_pc + 4; m_buffered = 0;
                end
            end else if (m_stale) begin
                if (mem_pronto) begin m_pc = m_pend; m_stale = 0; end
                if (!hazard) m_valid = 0;
            end else if (mem_pronto) begin
                if (hazard) begin
                    m_buf = img(m_pc); m_buffered = 1;
                end else begin
                    m_instr = img(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
                    m_pc = m_pc + 4;
                end
            end else if (!hazard) begin
                m_valid = 0;
            end
        end
    end

    // Compare process: every cycle, plus request-address stability.
    bit          prev_req = 0;
    logic [31:0] prev_addr = 0;
    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_req", mem_req, !reset && !m_buffered);
            if (!reset && !m_buffered) check("mem_endereco", mem_endereco, m_pc);
            check("valido_id", valido_id, m_valid);
            check("instrucao_id", instrucao_id, m_instr);
            check("pc_mais4_id", pc_mais4_id, m_pc4);
            check("erro_alinhamento", erro_alinhamento, m_err);
            if (!reset && prev_req && !mem_pronto) begin
                check("req estavel", mem_req, 1'b1);
                check("endereco estavel", mem_endereco, prev_addr);
            end
        end
        prev_req  = !reset && mem_req;
        prev_addr = mem_endereco;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int k = 0;
        while (!(mem_req && mem_endereco == a) && k < 50) begin
            step();
            k++;
        end
        check("espera endereco", mem_endereco, a);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;

        // Reset release with zero-wait memory.
        reset = 1'b0;
        check("pos-reset endereco", mem_endereco, 32'h00400000);
        check("pos-reset valido", valido_id, 1'b0);
        check("pos-reset instrucao", instrucao_id, 32'h0);
        check("pos-reset pc4", pc_mais4_id, 32'h0);
        step();
        check("primeira valida", valido_id, 1'b1);
        check("primeira pc4", pc_mais4_id, 32'h00400004);
        check("primeira instrucao", instrucao_id, img(32'h00400000));
        check("segundo endereco", mem_endereco, 32'h00400004);
        step();
        check("terceiro endereco", mem_endereco, 32'h00400008);
        check("segunda pc4", pc_mais4_id, 32'h00400008);
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("reset imediato valido", valido_id, 1'b0);
        check("reset imediato req", mem_req, 1'b0);
        repeat (2) step();
        reset = 1'b0;

        // Two-cycle memory: one bubble per instruction.
        lat_min = 1; lat_max = 1;
        repeat (30) step();

        // Hazard as the word from 0x8 returns.
        lat_min = 0; lat_max = 0;
        redireciona = 1'b1; alvo = 32'h0;
        step();
        redireciona = 1'b0;
        wait_addr(32'h00000008);
        hazard = 1'b1;
        step();
        check("retido req", mem_req, 1'b0);
        check("retido instrucao", instrucao_id, img(32'h00000004));
        check("retido pc4", pc_mais4_id, 32'h00000008);
        repeat (2) step();
        hazard = 1'b0;
        step();
        check("liberado instrucao", instrucao_id, 32'h8C220004);
        check("liberado pc4", pc_mais4_id, 32'h0000000C);
        check("liberado endereco", mem_endereco, 32'h0000000C);

        // Three-cycle memory, redirect while the 0x10 request is outstanding.
        lat_min = 2; lat_max = 2;
        redireciona = 1'b1; alvo = 32'h00000010;
        step();
        redireciona = 1'b0;
        wait_addr(32'h00000010);
        step();
        redireciona = 1'b1; alvo = 32'h00000100;
        step();
        redireciona = 1'b0;
        check("descarte endereco", mem_endereco, 32'h00000010);
        check("descarte valido", valido_id, 1'b0);
        step();
        check("apos descarte endereco", mem_endereco, 32'h00000100);
        check("apos descarte valido", valido_id, 1'b0);
        repeat (8) step();

        // Misaligned redirect.
        lat_min = 0; lat_max = 0;
        repeat (3) step();
        redireciona = 1'b1; alvo = 32'h00000202;
        step();
        redireciona = 1'b0;
        check("erro pulso", erro_alinhamento, 1'b1);
        check("erro valido", valido_id, 1'b0);
        check("erro endereco", mem_endereco, 32'h00000200);
        step();
        check("erro fim", erro_alinhamento, 1'b0);
        check("erro pc4", pc_mais4_id, 32'h00000204);

        // Redirect under hazard while holding a word; target at the top of memory.
        hazard = 1'b1;
        step();
        check("retido req 2", mem_req, 1'b0);
        step();
        redireciona = 1'b1; alvo = 32'hFFFFFFFC;
        step();
        redireciona = 1'b0; hazard = 1'b0;
        check("redir retido valido", valido_id, 1'b0);
        check("redir retido endereco", mem_endereco, 32'hFFFFFFFC);
        step();
        check("wrap valido", valido_id, 1'b1);
        check("wrap pc4", pc_mais4_id, 32'h00000000);
        check("wrap instrucao", instrucao_id, img(32'hFFFFFFFC));
        check("wrap endereco", mem_endereco, 32'h00000000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                lat_min = 0;
                lat_max = $urandom_range(3, 0);
            end
            hazard      = ($urandom_range(3, 0) == 0);
            redireciona = ($urandom_range(9, 0) == 0);
            if ($urandom_range(3, 0) == 0) alvo = 32'hFFFFFFF0 | 32'($urandom_range(15, 0));
            else alvo = $urandom;
            if (i == 1777) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step();
        end
        hazard = 1'b0;
        redireciona = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/estagio_busca.md
Name: estagio_busca

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage register file and decoder.
- Owns the program counter and issues requests to instruction memory over a req/ready handshake.
- Accepts redirects (branch/jump) from ID and honours the `hazard` stall.
- Delivers instruction, PC+4 and a valid bit to ID. PC+4 is the source for the link data written to register 31.

Parameters:
- VETOR_RESET, 32'h00000000, PC value loaded on reset.
- LARGURA, 32, address/data width; all arithmetic is modulo 2^LARGURA.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- hazard  in  1  ID stall; IF/ID holds its contents and the PC does not advance.
- redireciona  in  1  one-cycle pulse from ID: taken branch or jump.
- alvo  in  32  redirect target; bits [1:0] ignored.
- mem_req  out  1  instruction memory request.
- mem_endereco  out  32  word-aligned fetch address.
- mem_pronto  in  1  memory response strobe, one cycle per request.
- mem_dado  in  32  instruction; valid when mem_pronto=1.
- instrucao_id  out  32  IF/ID instruction.
- pc_mais4_id  out  32  IF/ID fetch PC + 4.
- valido_id  out  1  IF/ID contents are a real instruction.
- erro_alinhamento  out  1  one-cycle pulse when alvo[1:0] != 0 on a redirect.

Behaviour:
- Reset (async, any state): pc=VETOR_RESET, estado=REQ, valido_id=0, instrucao_id=0 (NOP), pc_mais4_id=0, buffer cleared, erro_alinhamento=0. mem_req forced 0 while reset=1.
- mem_req=1 in states REQ and DESCARTE, 0 in RETIDO. mem_endereco=pc, with {pc[31:2],2'b00} enforced.
- Memory protocol:
  - While mem_req=1, mem_endereco is stable until the edge at which mem_pronto=1 is sampled.
  - mem_pronto may arrive in the same cycle as the request (zero-wait memory).
  - Zero-wait memory with hazard=0 sustains 1 instruction/cycle.
- Priority at each rising edge: reset > redireciona > hazard > normal.
- State REQ:
  - mem_pronto=1, hazard=0: IF/ID <= {mem_dado, pc+4, valid=1}; pc<=pc+4; stay REQ.
  - mem_pronto=1, hazard=1: IF/ID holds; buffer<=mem_dado; go to RETIDO.
  - mem_pronto=0, hazard=0: valido_id<=0 (bubble).
  - mem_pronto=0, hazard=1: IF/ID holds.
- State RETIDO:
  - hazard=0: IF/ID <= {buffer, pc+4, 1}; pc<=pc+4; go to REQ.
  - hazard=1: hold.
- State DESCARTE (a stale request is outstanding):
  - mem_req stays high on the old pc.
  - On mem_pronto: discard mem_dado; pc<=pc_pendente; go to REQ.
  - valido_id<=0 every cycle in this state unless hazard=1.
- Redirect (redireciona=1), in any state:
  - valido_id<=0 (flush, even if hazard=1); erro_alinhamento<=(alvo[1:0]!=0).
  - REQ with mem_pronto=1: discard data; pc<=alvo&~3; stay REQ.
  - REQ with mem_pronto=0: pc_pendente<=alvo&~3; go to DESCARTE.
  - DESCARTE: pc_pendente overwritten. If mem_pronto=1 in the same cycle, pc<=new target and go to REQ.
  - RETIDO: drop buffer; pc<=alvo&~3; go to REQ.
- Wrap-around: pc=32'hFFFFFFFC advances to 0; pc_mais4_id=0 in that case.
- An unused state encoding recovers to REQ.

Decomposition:
- Package `pkg_busca`:
  - State enum {REQ, RETIDO, DESCARTE}.
  - NOP constant 32'h00000000.
  - Default VETOR_RESET.
- Single sub-module `registrador_if_id`: IF/ID register with load/flush/hold controls and async reset. The PC, FSM and buffer stay in the top module.

Test Plan:
- Reset mid-fetch, VETOR_RESET=32'h00400000, zero-wait memory, hazard=0 -> mem_endereco 00400000, 00400004, 00400008 on consecutive cycles. valido_id=1 from the first post-reset edge; pc_mais4_id tracks 00400004 onward. Asserting reset mid-stream -> valido_id=0 immediately.
- Memory with 2-cycle latency -> one bubble (valido_id=0) between instructions. mem_endereco stable while mem_req=1.
- Zero-wait memory; hazard=1 in the cycle mem_pronto returns 32'h8C220004 from 00000008 -> state RETIDO, mem_req=0, IF/ID unchanged. hazard=0 three cycles later -> instrucao_id=8C220004, pc_mais4_id=0000000C; next fetch at 0000000C.
- 3-cycle memory; redirect to 00000100 one cycle after a request to 00000010 -> request held at 00000010. Its returned data is discarded, never valid in ID. Next request at 00000100.
- Redirect to 00000202 -> erro_alinhamento pulses 1 cycle; fetch address 00000200; valido_id=0 for the flushed slot.
- Redirect with hazard=1 while in RETIDO -> buffer dropped, valido_id=0. Next fetch is at the target. pc=FFFFFFFC fetch -> pc_mais4_id=00000000, next fetch at 00000000.
